memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//  Shares the single RAM port between instruction fetch and data (load/store) requests.
//  Sits between the caches and RAM. Generates the ihit/dhit pulses that the hazard unit
//  consumes to stall/release pipeline registers. Data wins by default; a starvation
//  counter guarantees fetch progress under sustained data traffic.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data word width
//  STARVE_MAX  4   consecutive data grants with fetch pending before fetch is forced (>=1)
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       reset, asynchronous, active-high
//  iREN       in   1       instruction read request
//  iaddr      in   ADDR_W  instruction address
//  dREN       in   1       data read request
//  dWEN       in   1       data write request
//  daddr      in   ADDR_W  data address
//  dstore     in   DATA_W  data write value
//  ihit       out  1       1-cycle pulse: fetch complete, iload valid
//  iload      out  DATA_W  fetched instruction (registered)
//  dhit       out  1       1-cycle pulse: data access complete, dload valid on reads
//  dload      out  DATA_W  loaded data (registered)
//  ram_req    out  1       RAM transaction request, held until ram_ack
//  ram_wen    out  1       1 = write, 0 = read
//  ram_addr   out  ADDR_W  RAM address (latched at grant)
//  ram_store  out  DATA_W  RAM write data (latched at grant)
//  ram_ack    in   1       RAM completes transaction this cycle
//  ram_load   in   DATA_W  RAM read data, valid with ram_ack
// BEHAVIOUR
//  - Reset: state=IDLE, starve_cnt=0; ihit, dhit, ram_req, ram_wen = 0; iload, dload,
//    ram_addr, ram_store = 0. Reset mid-transaction drops ram_req immediately; no hit issued.
//  - FSM states: IDLE, GRANT_I, GRANT_D, DONE. All outputs registered.
//  - IDLE: data_pend = dREN|dWEN. If data_pend and !(iREN && starve_cnt==STARVE_MAX)
//    -> GRANT_D; else if iREN -> GRANT_I; else stay. Grant latches address, write data,
//    ram_wen (dWEN wins if dREN&dWEN; ram_wen=0 for fetch) and asserts ram_req next cycle.
//  - GRANT_x: ram_req=1, addr/wen/store stable. Requests re-sampled nowhere in this state.
//    On ram_ack: ram_req=0, latch ram_load into iload (GRANT_I) or dload (GRANT_D, read
//    only; dload unchanged on write), pulse ihit/dhit for exactly the DONE cycle -> DONE.
//  - DONE: hit high one cycle; -> IDLE unconditionally. Requesters change their request
//    on the edge ending DONE; IDLE therefore never re-grants a completed request.
//  - Latency: request seen in IDLE at cycle 0 -> ram_req at 1 -> ack at k>=1 -> hit at k+1.
//    Zero-wait RAM (ack in first GRANT cycle): hit 2 cycles after the IDLE sample.
//  - starve_cnt (width clog2(STARVE_MAX+1)): +1 on each data grant taken while iREN=1,
//    saturating at STARVE_MAX; cleared on fetch grant or any IDLE cycle with iREN=0.
//  - Requester deasserts during GRANT_x: transaction still completes, hit still pulses.
//  - ram_ack outside GRANT_x is ignored. ihit and dhit never both high.
// TESTING
//  1 Reset: RST=1 mid GRANT_D -> ram_req=0 async, state IDLE, no dhit after release.
//  2 Fetch only: iREN=1, iaddr=0x40, ram_ack 3 cycles after ram_req, ram_load=0xDEADBEEF
//    -> ram_addr=0x40, ram_wen=0, one ihit cycle, iload=0xDEADBEEF.
//  3 Simultaneous iREN & dREN, starve_cnt=0 -> data granted first; fetch granted after dhit.
//  4 Store: dWEN=dREN=1, daddr=0x100, dstore=0x12345678 -> ram_wen=1, ram_store=0x12345678,
//    dhit pulses, dload unchanged.
//  5 Starvation: iREN held, dREN re-asserted every IDLE, STARVE_MAX=4 -> exactly 4 dhit
//    pulses, then ihit, then starve_cnt=0 and data granted again.
//  6 Zero-wait RAM, ram_ack tied 1 -> hit every 3rd cycle, back-to-back fetches, ihit/dhit
//    never simultaneous; spurious ram_ack in IDLE causes no hit.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch after STARVE_MAX data grants.
module memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ram_req,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_load
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              ihit_q, ihit_d, dhit_q, dhit_d;
    logic [DATA_W-1:0] iload_q, iload_d, dload_q, dload_d;
    logic              req_q, req_d, wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;

    logic data_pend, force_i;
    assign data_pend = dREN | dWEN;
    assign force_i   = iREN && (starve_q == STARVE_LIM);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ihit_d   = ihit_q;
        dhit_d   = dhit_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        req_d    = req_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        case (state_q)
            IDLE: begin
                if (data_pend && !force_i) begin
                    state_d = GRANT_D;
                    req_d   = 1'b1;
                    wen_d   = dWEN;
                    addr_d  = daddr;
                    store_d = dstore;
                    if (!iREN)
                        starve_d = '0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + 1'b1;
                end else if (iREN) begin
                    state_d  = GRANT_I;
                    req_d    = 1'b1;
                    wen_d    = 1'b0;
                    addr_d   = iaddr;
                    starve_d = '0;
                end else begin
                    starve_d = '0;
                end
            end
            GRANT_I: begin
                if (ram_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    iload_d = ram_load;
                    ihit_d  = 1'b1;
                end
            end
            GRANT_D: begin
                if (ram_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    dhit_d  = 1'b1;
                    // stores leave the last loaded word visible
                    if (!wen_q)
                        dload_d = ram_load;
                end
            end
            DONE: begin
                state_d = IDLE;
                ihit_d  = 1'b0;
                dhit_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
            req_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ihit_q   <= ihit_d;
            dhit_q   <= dhit_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            req_q    <= req_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
        end
    end

    assign ihit      = ihit_q;
    assign dhit      = dhit_q;
    assign iload     = iload_q;
    assign dload     = dload_q;
    assign ram_req   = req_q;
    assign ram_wen   = wen_q;
    assign ram_addr  = addr_q;
    assign ram_store = store_q;

endmodule
